// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: turns execute results and memory load data into a registered
// one-cycle regfile write pulse, owns the NZP condition codes, tracks one pending load.
module lc3_writeback #(
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8,
    parameter logic [2:0]  RESET_CC = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  ex_dr,
    input  logic [15:0] ex_data,
    input  logic        ex_wb_en,
    input  logic        ex_set_cc,
    input  logic        ex_is_load,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        rf_we,
    output logic [2:0]  rf_dr,
    output logic [15:0] rf_d,
    output logic        cc_n,
    output logic        cc_z,
    output logic        cc_p,
    output logic        busy,
    output logic        mem_err
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       load_dr_reg, load_dr_next;
    logic             load_set_cc_reg, load_set_cc_next;
    logic             rf_we_reg, rf_we_next;
    logic [2:0]       rf_dr_reg, rf_dr_next;
    logic [15:0]      rf_d_reg, rf_d_next;
    logic [2:0]       cc_reg, cc_next;
    logic             mem_err_reg, mem_err_next;

    logic             in_idle;
    logic             accept;
    logic             timeout_hit;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        logic is_zero;
        is_zero = (v == 16'h0000);
        return {v[15], is_zero, ~v[15] & ~is_zero};
    endfunction

    // Handshake outputs depend on state alone so execute never sees an input-to-output path.
    assign in_idle     = (state_reg == ST_IDLE);
    assign ex_ready    = in_idle;
    assign busy        = ~in_idle;
    assign accept      = ex_valid & in_idle;
    assign timeout_hit = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        load_dr_next     = load_dr_reg;
        load_set_cc_next = load_set_cc_reg;
        rf_we_next       = 1'b0;
        rf_dr_next       = rf_dr_reg;
        rf_d_next        = rf_d_reg;
        cc_next          = cc_reg;
        mem_err_next     = mem_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (ex_is_load) begin
                        load_dr_next     = ex_dr;
                        load_set_cc_next = ex_set_cc;
                        cnt_next         = '0;
                        state_next       = ST_WAIT_MEM;
                    end else begin
                        if (ex_wb_en) begin
                            rf_we_next = 1'b1;
                            rf_dr_next = ex_dr;
                            rf_d_next  = ex_data;
                        end
                        if (ex_set_cc) begin
                            cc_next = nzp_of(ex_data);
                        end
                    end
                end
            end

            ST_WAIT_MEM: begin
                // Data arriving on the last allowed cycle still beats the timeout.
                if (mem_rvalid) begin
                    rf_we_next = 1'b1;
                    rf_dr_next = load_dr_reg;
                    rf_d_next  = mem_rdata;
                    if (load_set_cc_reg) begin
                        cc_next = nzp_of(mem_rdata);
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    mem_err_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            load_dr_reg     <= 3'd0;
            load_set_cc_reg <= 1'b0;
            rf_we_reg       <= 1'b0;
            rf_dr_reg       <= 3'd0;
            rf_d_reg        <= 16'h0000;
            mem_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            load_dr_reg     <= load_dr_next;
            load_set_cc_reg <= load_set_cc_next;
            rf_we_reg       <= rf_we_next;
            rf_dr_reg       <= rf_dr_next;
            rf_d_reg        <= rf_d_next;
            mem_err_reg     <= mem_err_next;
        end
    end

    // Each flag flop takes its own bit of the reset code.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cc
        always_ff @(posedge clk) begin
            if (rst) begin
                cc_reg[gi] <= RESET_CC[gi];
            end else begin
                cc_reg[gi] <= cc_next[gi];
            end
        end
    end

    assign rf_we   = rf_we_reg;
    assign rf_dr   = rf_dr_reg;
    assign rf_d    = rf_d_reg;
    assign cc_n    = cc_reg[2];
    assign cc_z    = cc_reg[1];
    assign cc_p    = cc_reg[0];
    assign mem_err = mem_err_reg;

endmodule
